// File: rtl/sandpile_grain_dropper_if.sv
// Drop-request handshake between the grain dropper (master) and the grid engine (slave).
interface sandpile_grain_dropper_if;
   logic       drop_valid;
   logic [9:0] drop_addr;
   logic       drop_ready;

   modport master (output drop_valid, output drop_addr, input drop_ready);
   modport slave  (input drop_valid, input drop_addr, output drop_ready);
endinterface

// File: rtl/sandpile_grain_dropper.sv
// Samples TRNG cell indices on a programmable tick into a FWFT FIFO and issues grain drops.
// Optional accepted-drop counter enabled by macro DROPPER_STATS_EN.
module sandpile_grain_dropper #(
   parameter int NUM_CELLS  = 480,
   parameter int FIFO_DEPTH = 4,
   parameter int PERIOD_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    clear,
   input  logic [PERIOD_W-1:0]     drop_period,
   input  logic [9:0]              random_in,
   sandpile_grain_dropper_if.master drop_if,
   output logic [7:0]              lost_cnt,
   output logic [15:0]             drop_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]                 state;
   logic [PERIOD_W-1:0]        period_cnt;
   logic [FIFO_DEPTH-1:0][9:0] mem;
   logic [AW-1:0]              wr_ptr, rd_ptr;
   logic [AW:0]                occ;
   logic                       tick, in_range, push_req, push, pop, full, empty;

   assign tick     = (state == RUN) && enable && (period_cnt == drop_period);
   assign in_range = {1'b0, random_in} < 11'(NUM_CELLS);
   assign push_req = tick && in_range;
   assign empty    = (occ == '0);
   assign full     = (occ == (AW+1)'(FIFO_DEPTH));
   assign pop      = !empty && drop_if.drop_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push     = push_req && (!full || pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         period_cnt <= '0;
      end else begin
         if (state == IDLE) begin
            period_cnt <= '0;
            if (enable) state <= RUN;
         end else if (!enable) begin
            state      <= IDLE;
            period_cnt <= '0;
         end else if (tick) begin
            period_cnt <= '0;
         end else begin
            period_cnt <= period_cnt + PERIOD_W'(1);
         end
         if (clear) period_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
         lost_cnt <= '0;
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
         lost_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      occ <= occ + (AW+1)'(1);
         else if (pop && !push) occ <= occ - (AW+1)'(1);
         if (push_req && full && !pop && lost_cnt != 8'hFF)
            lost_cnt <= lost_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= random_in;
   end

   // Storage is not reset, so the address is forced to zero whenever nothing is pending.
   assign drop_if.drop_valid = !empty;
   assign drop_if.drop_addr  = empty ? 10'd0 : mem[rd_ptr];

`ifdef DROPPER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     drop_cnt <= '0;
      else if (clear) drop_cnt <= '0;
      else if (pop)   drop_cnt <= drop_cnt + 16'd1;
   end
`else
   assign drop_cnt = '0;
`endif
endmodule
